lsu_mem_unit: RTL and testbench

//  Parametrised successor memory unit for the core. Takes one load/store command per handshake from the AGU
//  and decodes the address to the local data RAM or the ITA peripheral port. Performs lane alignment, byte

---
 rtl/mem_unit_pkg.sv | 78 +++++++
 rtl/lsu_ram_bank.sv | 36 +++
 rtl/lsu_mem_unit.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_mem_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_unit_pkg.sv
// Shared encodings and helpers for the load/store memory unit.
package mem_unit_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_DECODE   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } errcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_ITA_REQ,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Byte-enable pattern for an access of the given size, lane 0 justified.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Copy the LSB-justified store operand into every lane of the bus.
  function automatic logic [63:0] lane_replicate(input logic [63:0] data, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {8{data[7:0]}};
      SZ_H:    r = {4{data[15:0]}};
      SZ_W:    r = {2{data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend an LSB-justified load value.
  function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                         input logic usign);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{~usign & data[7]}}, data[7:0]};
      SZ_H:    r = {{48{~usign & data[15]}}, data[15:0]};
      SZ_W:    r = {{32{~usign & data[31]}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  // Subtract-then-compare so a window touching the top of the space cannot overflow.
  function automatic logic window_hit(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] len);
    return (addr >= base) && ((addr - base) < len);
  endfunction

  function automatic logic ram_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input logic [63:0] len);
    return window_hit(addr, base, len);
  endfunction

  function automatic logic ita_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input logic [63:0] len);
    return window_hit(addr, base, len);
  endfunction

endpackage

// File: rtl/lsu_ram_bank.sv
// Byte-masked synchronous single-port data RAM with a configurable read pipeline.
module lsu_ram_bank #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 1
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [XLEN-1:0]          wdata,
  input  logic [XLEN/8-1:0]        be,
  output logic [XLEN-1:0]          rdata
);

  localparam int unsigned NB = XLEN / 8;

  logic [XLEN-1:0] mem  [DEPTH];
  logic [XLEN-1:0] pipe [LAT];

  // Array write and read-pipeline shift; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (rd_en) pipe[0] <= mem[index];
    for (int unsigned s = 1; s < LAT; s++) begin
      pipe[s] <= pipe[s-1];
    end
  end

  assign rdata = pipe[LAT-1];

endmodule

// File: rtl/lsu_mem_unit.sv
// Load/store unit: decodes AGU commands to the local RAM or the ITA port,
// aligns lanes, extends loads and returns one response per command.
module lsu_mem_unit
  import mem_unit_pkg::*;
#(
  parameter int unsigned   XLEN        = 32,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   RAM_DEPTH   = 1024,
  parameter logic [AW-1:0] RAM_BASE    = 'h2000_0000,
  parameter logic [AW-1:0] ITA_BASE    = 'h4000_0000,
  parameter logic [AW-1:0] ITA_SIZE    = 'h1000_0000,
  parameter int unsigned   RAM_LAT     = 1,
  parameter int unsigned   ITA_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic              cmd_write,
  input  logic              cmd_usign,
  input  logic [1:0]        cmd_size,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [XLEN-1:0]   cmd_wdata,
  input  logic [XLEN/8-1:0] cmd_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_errcode,
  output logic              ita_valid,
  input  logic              ita_ready,
  output logic              ita_wr,
  output logic              ita_rd,
  output logic [AW-1:0]     ita_addr,
  output logic [XLEN-1:0]   ita_wdata,
  output logic [XLEN/8-1:0] ita_wmask,
  input  logic [XLEN-1:0]   ita_rdata
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned LB  = $clog2(NB);
  localparam int unsigned IW  = $clog2(RAM_DEPTH);
  localparam int unsigned RCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int unsigned SCW = (ITA_TIMEOUT > 1) ? $clog2(ITA_TIMEOUT) : 1;
  localparam logic [63:0] RAM_BYTES = 64'(RAM_DEPTH) * 64'(NB);

  state_e          state;
  errcode_e        code_q;
  errcode_e        acc_err;
  logic            accept;
  logic            misalign;
  logic            hit_ram;
  logic            hit_ita;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_rep;
  logic            ram_we;
  logic            ram_re;
  logic [IW-1:0]   ram_idx;
  logic [XLEN-1:0] ram_rdata;
  logic [XLEN-1:0] ld_src;
  logic [XLEN-1:0] ld_lane;
  logic [XLEN-1:0] ld_ext;
  logic [LB-1:0]   r_lane;
  logic [1:0]      r_size;
  logic            r_usign;
  logic            r_write;
  logic [RCW-1:0]  ram_cnt;
  logic [SCW-1:0]  stall_cnt;

  assign accept = cmd_valid & cmd_ready;

  // Accept-time checks: misalignment outranks decode errors.
  always_comb begin
    case (cmd_size)
      SZ_H:    misalign = cmd_addr[0];
      SZ_W:    misalign = |cmd_addr[1:0];
      SZ_D:    misalign = |cmd_addr[2:0];
      default: misalign = 1'b0;
    endcase
    hit_ram = ram_hit(64'(cmd_addr), 64'(RAM_BASE), RAM_BYTES);
    hit_ita = ita_hit(64'(cmd_addr), 64'(ITA_BASE), 64'(ITA_SIZE));
    acc_err = ERR_OK;
    if (misalign) begin
      acc_err = ERR_MISALIGN;
    end else if (!(hit_ram || hit_ita) || (cmd_read == cmd_write) ||
                 ((cmd_size == SZ_D) && (XLEN != 64))) begin
      acc_err = ERR_DECODE;
    end
  end

  assign be        = (NB'(size_mask(cmd_size)) << cmd_addr[LB-1:0]) & cmd_wmask;
  assign wdata_rep = XLEN'(lane_replicate(64'(cmd_wdata), cmd_size));
  assign ram_idx   = IW'((cmd_addr - RAM_BASE) >> LB);
  assign ram_we    = accept & (acc_err == ERR_OK) & hit_ram & cmd_write;
  assign ram_re    = accept & (acc_err == ERR_OK) & hit_ram & cmd_read;

  lsu_ram_bank #(
    .XLEN  (XLEN),
    .DEPTH (RAM_DEPTH),
    .LAT   (RAM_LAT)
  ) u_ram (
    .clk   (clk),
    .wr_en (ram_we),
    .rd_en (ram_re),
    .index (ram_idx),
    .wdata (wdata_rep),
    .be    (be),
    .rdata (ram_rdata)
  );

  assign ld_src  = (state == ST_ITA_REQ) ? ita_rdata : ram_rdata;
  assign ld_lane = ld_src >> {r_lane, 3'b000};
  assign ld_ext  = XLEN'(extend(64'(ld_lane), r_size, r_usign));

  assign rsp_errcode = code_q;
  assign rsp_err     = (code_q != ERR_OK);

  // Command FSM with registered handshake, ITA request and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      code_q    <= ERR_OK;
      ita_valid <= 1'b0;
      ita_wr    <= 1'b0;
      ita_rd    <= 1'b0;
      ita_addr  <= '0;
      ita_wdata <= '0;
      ita_wmask <= '0;
      r_lane    <= '0;
      r_size    <= '0;
      r_usign   <= 1'b0;
      r_write   <= 1'b0;
      ram_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            r_lane    <= cmd_addr[LB-1:0];
            r_size    <= cmd_size;
            r_usign   <= cmd_usign;
            r_write   <= cmd_write;
            if (acc_err != ERR_OK) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              code_q    <= acc_err;
            end else if (hit_ram) begin
              state   <= ST_RAM_WAIT;
              ram_cnt <= '0;
            end else begin
              state     <= ST_ITA_REQ;
              ita_valid <= 1'b1;
              ita_wr    <= cmd_write;
              ita_rd    <= cmd_read;
              ita_addr  <= cmd_addr;
              ita_wdata <= wdata_rep;
              ita_wmask <= be;
              stall_cnt <= '0;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (ram_cnt == RCW'(RAM_LAT - 1)) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_write ? '0 : ld_ext;
            code_q    <= ERR_OK;
          end else begin
            ram_cnt <= ram_cnt + 1'b1;
          end
        end
        ST_ITA_REQ: begin
          // ita_ready is checked first so a completion on the final stall cycle still succeeds.
          if (ita_ready) begin
            state     <= ST_RESP;
            ita_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_write ? '0 : ld_ext;
            code_q    <= ERR_OK;
          end else if (stall_cnt == SCW'(ITA_TIMEOUT - 1)) begin
            state     <= ST_RESP;
            ita_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            code_q    <= ERR_TIMEOUT;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Scoreboard bench for lsu_mem_unit with a byte-level reference model.
module tb_lsu_mem_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 32;
  localparam int unsigned DEPTH    = 1024;
  localparam bit [31:0]   RB       = 32'h2000_0000;
  localparam bit [31:0]   IB       = 32'h4000_0000;
  localparam bit [31:0]   IS       = 32'h1000_0000;
  localparam int unsigned LAT      = 3;
  localparam int unsigned TMO      = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read, cmd_write, cmd_usign;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_errcode;
  logic        ita_valid, ita_ready, ita_wr, ita_rd;
  logic [31:0] ita_addr, ita_wdata, ita_rdata;
  logic [3:0]  ita_wmask;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  code;
  } rsp_t;

  typedef struct {
    bit [31:0] addr;
    bit        wr;
    bit [31:0] wdata;
    bit [3:0]  wmask;
    bit [31:0] word;
    int        delay;
  } ita_t;

  rsp_t      exp_q[$];
  ita_t      ita_q[$];
  bit [7:0]  ram_m [bit [31:0]];
  int        checks   = 0;
  int        failures = 0;
  bit        hold_rsp = 1'b0;

  lsu_mem_unit #(
    .XLEN        (XLEN),
    .AW          (AW),
    .RAM_DEPTH   (DEPTH),
    .RAM_BASE    (RB),
    .ITA_BASE    (IB),
    .ITA_SIZE    (IS),
    .RAM_LAT     (LAT),
    .ITA_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_read    (cmd_read),
    .cmd_write   (cmd_write),
    .cmd_usign   (cmd_usign),
    .cmd_size    (cmd_size),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wmask   (cmd_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_errcode (rsp_errcode),
    .ita_valid   (ita_valid),
    .ita_ready   (ita_ready),
    .ita_wr      (ita_wr),
    .ita_rd      (ita_rd),
    .ita_addr    (ita_addr),
    .ita_wdata   (ita_wdata),
    .ita_wmask   (ita_wmask),
    .ita_rdata   (ita_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Contents the ITA peripheral returns for the word containing an address.
  function automatic bit [31:0] ita_word(input bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Extend an n-byte value to 32 bits.
  function automatic bit [31:0] ext(input bit [31:0] v, input int n, input bit us);
    bit [31:0] r;
    bit        s;
    r = v;
    if (n >= 4) return r;
    s = v[8*n-1];
    for (int i = n; i < 4; i++) r[8*i +: 8] = (us || !s) ? 8'h00 : 8'hFF;
    return r;
  endfunction

  // Issue one command: model it, push expectations, handshake, check latency.
  task automatic issue(input bit rd, input bit wr, input bit us, input bit [1:0] sz,
                       input bit [31:0] a, input bit [31:0] wd, input bit [3:0] wm,
                       input int d);
    int        n;
    int        off;
    int        lat;
    int        exp_lat;
    int        g;
    bit        mis, in_ram, in_ita;
    bit [31:0] v;
    rsp_t      r;
    ita_t      it;
    n   = 1 << sz;
    off = int'(a[1:0]);
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (sz == 2'd3 && a[2:0] != 0);
    in_ram = (longint'(a) >= longint'(RB)) && (longint'(a) < longint'(RB) + DEPTH * 4);
    in_ita = (longint'(a) >= longint'(IB)) && (longint'(a) < longint'(IB) + longint'(IS));
    r.rdata = '0;
    it = '{addr: a, wr: wr, wdata: '0, wmask: '0, word: ita_word(a & ~32'h3), delay: d};
    if (mis) begin
      r.code = 2'd1; exp_lat = 1;
    end else if (!(in_ram || in_ita) || rd == wr || sz == 2'd3) begin
      r.code = 2'd2; exp_lat = 1;
    end else if (in_ram) begin
      r.code = 2'd0; exp_lat = LAT + 1;
      if (wr) begin
        for (int i = 0; i < n; i++)
          if (wm[off + i]) ram_m[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ram_m[a + i];
        r.rdata = ext(v, n, us);
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        it.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
        it.wmask[j] = (j >= off) && (j < off + n) && wm[j];
      end
      if (d < TMO) begin
        r.code = 2'd0; exp_lat = d + 2;
        if (!wr) begin
          v = '0;
          for (int i = 0; i < n; i++) v[8*i +: 8] = it.word[8*(off + i) +: 8];
          r.rdata = ext(v, n, us);
        end
      end else begin
        r.code = 2'd3; exp_lat = TMO + 1;
      end
    end
    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    if (!cmd_ready) return;
    exp_q.push_back(r);
    if (r.code == 2'd0 && in_ita) ita_q.push_back(it);
    if (r.code == 2'd3) ita_q.push_back(it);
    cmd_valid = 1; cmd_read = rd; cmd_write = wr; cmd_usign = us;
    cmd_size = sz; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    @(negedge clk);
    cmd_valid = 0; cmd_read = $urandom; cmd_write = $urandom; cmd_usign = $urandom;
    cmd_size = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wmask = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("latency", lat, exp_lat);
  endtask

  // Writeback backpressure, changed just after each rising edge.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor: every cycle a response is shown it must match the queue head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_errcode", rsp_errcode, e.code);
          chk("rsp_err", rsp_err, e.code != 2'd0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ITA responder: checks request fields each cycle and answers after the planned delay.
  initial begin
    ita_t e;
    bit   ev;
    ita_ready = 1'b0;
    ita_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ita_valid) begin
        if (ita_q.size() == 0) begin
          chk("ita_unexpected", ita_valid, 0);
        end else begin
          e = ita_q.pop_front();
          for (int k = 0; k <= e.delay; k++) begin
            if (k > 0) @(negedge clk);
            ev = (k < TMO);
            chk("ita_valid", ita_valid, ev);
            if (ev) begin
              chk("ita_addr", ita_addr, e.addr);
              chk("ita_wr", ita_wr, e.wr);
              chk("ita_rd", ita_rd, !e.wr);
              if (e.wr) begin
                chk("ita_wdata", ita_wdata, e.wdata);
                chk("ita_wmask", ita_wmask, e.wmask);
              end
            end
            if (k == e.delay) begin
              ita_ready = 1'b1;
              ita_rdata = e.word;
            end
          end
          @(negedge clk);
          ita_ready = 1'b0;
          ita_rdata = '0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] bad_addr [6];
    int        g;
    int        sel;
    int        rw;
    bit        rd, wr;
    bit [31:0] a;
    bad_addr = '{32'h0000_0000, RB - 32'd4, RB + DEPTH * 4, IB - 32'd4, IB + IS, 32'hFFFF_FFFC};

    rst_n = 1'b0;
    cmd_valid = 0; cmd_read = 0; cmd_write = 0; cmd_usign = 0;
    cmd_size = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wmask = 0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_ita_valid", ita_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_errcode", rsp_errcode, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) issue(0, 1, 0, 2'd2, RB + 4 * i, $urandom, 4'hF, 0);

    issue(0, 1, 0, 2'd2, RB + 4, 32'hDEAD_BEEF, 4'hF, 0);
    issue(1, 0, 0, 2'd0, RB + 7, 0, 4'hF, 0);
    issue(1, 0, 1, 2'd0, RB + 7, 0, 4'hF, 0);

    issue(0, 1, 0, 2'd1, RB + 2, 32'h0000_1234, 4'hF, 0);
    issue(1, 0, 0, 2'd2, RB + 0, 0, 4'hF, 0);

    issue(1, 0, 0, 2'd2, RB + 2, 0, 4'hF, 0);
    issue(0, 1, 0, 2'd2, RB + 2, 32'hFFFF_FFFF, 4'hF, 0);
    issue(1, 0, 0, 2'd2, RB + 0, 0, 4'hF, 0);
    issue(1, 0, 0, 2'd2, 32'h0000_0000, 0, 4'hF, 0);
    issue(1, 0, 0, 2'd3, RB + 8, 0, 4'hF, 0);
    issue(1, 1, 0, 2'd0, RB + 1, 0, 4'hF, 0);
    issue(0, 0, 0, 2'd0, IB + 1, 0, 4'hF, 0);
    issue(1, 0, 0, 2'd2, IB + IS, 0, 4'hF, 0);
    issue(1, 0, 0, 2'd2, IB + IS - 4, 0, 4'hF, 0);

    issue(0, 1, 0, 2'd2, IB + 8, 32'hCAFE_F00D, 4'hF, 5);
    issue(1, 0, 0, 2'd2, IB + 0, 0, 4'hF, TMO);
    issue(1, 0, 0, 2'd1, IB + 6, 0, 4'hF, TMO - 1);

    hold_rsp = 1'b1;
    issue(1, 0, 0, 2'd2, RB + 4, 0, 4'hF, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      @(negedge clk);
    end
    hold_rsp = 1'b0;

    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("mid_reset_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_read = 1; cmd_write = 0; cmd_usign = 0;
    cmd_size = 2'd2; cmd_addr = RB; cmd_wmask = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", rsp_valid, 0);
    chk("mid_reset_cmd_ready", cmd_ready, 0);
    chk("mid_reset_ita_valid", ita_valid, 0);
    chk("mid_reset_rsp_errcode", rsp_errcode, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1, 0, 1, 2'd1, RB + 6, 0, 4'hF, 0);

    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      a = RB + $urandom_range(0, 63);
      else if (sel <= 7) a = IB + $urandom_range(0, 255);
      else if (sel == 8) a = bad_addr[$urandom_range(0, 5)];
      else               a = IB + IS - $urandom_range(1, 8);
      rw = $urandom_range(0, 9);
      if (rw == 0)      begin rd = 0; wr = 0; end
      else if (rw == 1) begin rd = 1; wr = 1; end
      else              begin rd = $urandom_range(0, 1); wr = !rd; end
      issue(rd, wr, 1'($urandom), 2'($urandom_range(0, 3)), a, $urandom,
            ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom), $urandom_range(0, TMO));
    end

    g = 0;
    while (exp_q.size() != 0 && g < 500) begin @(negedge clk); g++; end
    chk("drain_rsp", exp_q.size(), 0);
    chk("drain_ita", ita_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
